// File: rtl/adc_capture_ctrl.sv
// ADC capture window sequencer: waits for an immediate or threshold trigger, then writes
// capture_len (optionally decimated) samples to the buffer RAM from address 0.
module adc_capture_ctrl #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              rst,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_otr_i,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_mode,
    input  logic [DATA_W-1:0] threshold,
    input  logic [ADDR_W:0]   capture_len,
    input  logic [7:0]        decim,
    output logic              wr_clk,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              done_pulse,
    output logic [ADDR_W:0]   sample_count,
    output logic              otr_seen,
    output logic [1:0]        state
);

    // state   | meaning
    // IDLE    | waiting for arm with a non-zero length
    // ARMED   | configuration latched, waiting for trigger
    // CAPTURE | writing samples (with decimation) to the buffer
    // DONE    | capture complete, counters held until re-arm or abort
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // The otr flag sits just above the sample field, which is at least 12 bits wide.
    localparam int SMP_W = (DATA_W > 12) ? DATA_W : 12;
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            st, st_n;
    logic [DATA_W-1:0] s_cur, s_prev;
    logic              s_cur_otr;
    logic [ADDR_W:0]   len_q;
    logic [7:0]        decim_q;
    logic              mode_q;
    logic [DATA_W-1:0] thr_q;
    logic [7:0]        dcnt;

    logic              arm_req;
    logic              arm_ok;
    logic              abort_go;
    logic              trig;
    logic              proc;
    logic              wr_go;
    logic              last;
    logic [ADDR_W:0]   cnt_inc;
    logic [ADDR_W:0]   len_clamp;
    logic [31:0]       wdata_n;

    assign wr_clk    = clk_i;
    assign state     = st;
    assign busy      = (st == S_ARMED) || (st == S_CAPTURE);
    assign arm_req   = arm && (capture_len != '0) && !abort;
    assign trig      = (s_prev < thr_q) && (s_cur >= thr_q);
    assign cnt_inc   = sample_count + CNT_ONE;
    assign len_clamp = (capture_len > DEPTH) ? DEPTH : capture_len;

    always_comb begin
        wdata_n                = '0;
        wdata_n[DATA_W-1:0]    = s_cur;
        wdata_n[SMP_W]         = s_cur_otr;
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= st_n;
    end

    always_comb begin
        st_n     = st;
        arm_ok   = 1'b0;
        abort_go = 1'b0;
        proc     = 1'b0;
        case (st)
            S_IDLE: begin
                if (arm_req) begin
                    st_n   = S_ARMED;
                    arm_ok = 1'b1;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    st_n     = S_IDLE;
                    abort_go = 1'b1;
                end else if (!mode_q) begin
                    st_n = S_CAPTURE;
                end else if (trig) begin
                    // the triggering sample is itself the first one processed
                    st_n = S_CAPTURE;
                    proc = 1'b1;
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    st_n     = S_IDLE;
                    abort_go = 1'b1;
                end else begin
                    proc = 1'b1;
                end
            end
            S_DONE: begin
                if (abort) begin
                    st_n     = S_IDLE;
                    abort_go = 1'b1;
                end else if (arm_req) begin
                    st_n   = S_ARMED;
                    arm_ok = 1'b1;
                end
            end
            default: st_n = S_IDLE;
        endcase
        wr_go = proc && (dcnt == 8'd0);
        last  = wr_go && (cnt_inc == len_q);
        if (last) st_n = S_DONE;
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            s_cur        <= '0;
            s_cur_otr    <= 1'b0;
            s_prev       <= '0;
            len_q        <= '0;
            decim_q      <= '0;
            mode_q       <= 1'b0;
            thr_q        <= '0;
            dcnt         <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            done         <= 1'b0;
            done_pulse   <= 1'b0;
            sample_count <= '0;
            otr_seen     <= 1'b0;
        end else begin
            s_cur      <= adc_data;
            s_cur_otr  <= adc_otr_i;
            s_prev     <= s_cur;
            wr_en      <= wr_go;
            done_pulse <= last;
            if (arm_ok) begin
                len_q        <= len_clamp;
                decim_q      <= decim;
                mode_q       <= trig_mode;
                thr_q        <= threshold;
                dcnt         <= '0;
                sample_count <= '0;
                otr_seen     <= 1'b0;
                done         <= 1'b0;
            end
            if (abort_go) done <= 1'b0;
            if (proc) dcnt <= (dcnt == decim_q) ? 8'd0 : dcnt + 8'd1;
            if (wr_go) begin
                wr_addr      <= sample_count[ADDR_W-1:0];
                wr_data      <= wdata_n;
                sample_count <= cnt_inc;
                otr_seen     <= otr_seen | s_cur_otr;
            end
            if (last) done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: expected RAM writes are queued as stimulus is driven and
// matched against every wr_en seen by the write-port monitor.
module tb_adc_capture_ctrl;

    localparam int DATA_W = 12;
    localparam int ADDR_W = 14;

    logic              clk_i = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] adc_data;
    logic              adc_otr_i;
    logic              arm;
    logic              abort;
    logic              trig_mode;
    logic [DATA_W-1:0] threshold;
    logic [ADDR_W:0]   capture_len;
    logic [7:0]        decim;
    logic              wr_clk;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              done_pulse;
    logic [ADDR_W:0]   sample_count;
    logic              otr_seen;
    logic [1:0]        state;

    adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_otr_i    (adc_otr_i),
        .arm          (arm),
        .abort        (abort),
        .trig_mode    (trig_mode),
        .threshold    (threshold),
        .capture_len  (capture_len),
        .decim        (decim),
        .wr_clk       (wr_clk),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .done_pulse   (done_pulse),
        .sample_count (sample_count),
        .otr_seen     (otr_seen),
        .state        (state)
    );

    always #5 clk_i = ~clk_i;

    int                n_cmp = 0;
    int                n_err = 0;
    int                wr_cnt = 0;
    int                pulses = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [45:0]       exp_q[$];
    logic [45:0]       e;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int a, input logic [11:0] d, input logic o);
        exp_q.push_back({14'(a), 19'd0, o, d});
    endtask

    // Inputs change 1 time unit after the falling edge; the next rising edge samples them.
    task automatic step(input logic [11:0] d, input logic o, input logic a, input logic ab);
        @(negedge clk_i);
        #1;
        adc_data  = d;
        adc_otr_i = o;
        arm       = a;
        abort     = ab;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc; i++) begin
            if (done) break;
            @(negedge clk_i);
            #1;
        end
        chk(tag, done, 1);
    endtask

    always @(negedge clk_i) begin
        if (!rst) begin
            if (done_pulse) pulses++;
            if (wr_en) begin
                wr_cnt++;
                last_addr = wr_addr;
                if (exp_q.size() == 0) begin
                    chk("extra_wr", {wr_addr, wr_data}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", wr_addr, e[45:32]);
                    chk("wr_data", wr_data, e[31:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int p0;
        rst         = 1'b1;
        adc_data    = '0;
        adc_otr_i   = 1'b0;
        arm         = 1'b0;
        abort       = 1'b0;
        trig_mode   = 1'b0;
        threshold   = '0;
        capture_len = '0;
        decim       = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_wr", {wr_en, wr_addr, wr_data}, 0);
        chk("reset_stat", {busy, done, done_pulse, sample_count, otr_seen, state}, 0);
        rst = 1'b0;
        step(0, 0, 0, 0);

        // 1: immediate trigger, ramp; first written sample is the one after the arm edge
        trig_mode = 0; capture_len = 4; decim = 0;
        base = wr_cnt; p0 = pulses;
        for (int k = 1; k <= 4; k++) push(k - 1, 12'(100 + k), 0);
        for (int i = 0; i < 12; i++) step(12'(100 + i), 0, (i == 0), 0);
        wait_done(20, "t1_done");
        chk("t1_wrcnt", wr_cnt - base, 4);
        chk("t1_pulse", pulses - p0, 1);
        chk("t1_state", state, 3);
        chk("t1_count", sample_count, 4);

        // 2: rising threshold crossing re-armed from DONE
        trig_mode = 1; threshold = 12'h800; capture_len = 3; decim = 0;
        repeat (3) step(12'h7FE, 0, 0, 0);
        step(12'h7FE, 0, 1, 0);
        base = wr_cnt;
        repeat (5) step(12'h7FE, 0, 0, 0);
        chk("t2_armed", state, 1);
        chk("t2_busy", busy, 1);
        chk("t2_nowr", wr_cnt - base, 0);
        push(0, 12'h800, 0); push(1, 12'h900, 0); push(2, 12'h901, 0);
        step(12'h7FF, 0, 0, 0);
        step(12'h800, 0, 0, 0);
        step(12'h900, 0, 0, 0);
        step(12'h901, 0, 0, 0);
        step(12'h902, 0, 0, 0);
        step(12'h903, 0, 0, 0);
        wait_done(20, "t2_done");
        chk("t2_wrcnt", wr_cnt - base, 3);
        chk("t2_state", state, 3);

        // 3: decimation by 3
        trig_mode = 0; capture_len = 3; decim = 2;
        base = wr_cnt;
        push(0, 0, 0); push(1, 3, 0); push(2, 6, 0);
        step(500, 0, 1, 0);
        for (int k = 0; k < 10; k++) step(12'(k), 0, 0, 0);
        wait_done(20, "t3_done");
        chk("t3_wrcnt", wr_cnt - base, 3);
        chk("t3_count", sample_count, 3);

        // 4: abort after 5 writes, then arm+abort together
        capture_len = 16; decim = 0;
        base = wr_cnt; p0 = pulses;
        for (int k = 1; k <= 5; k++) push(k - 1, 12'(200 + k), 0);
        step(200, 0, 1, 0);
        for (int k = 1; k <= 6; k++) step(12'(200 + k), 0, 0, 0);
        step(207, 0, 0, 1);
        repeat (4) step(208, 0, 0, 0);
        chk("t4_wrcnt", wr_cnt - base, 5);
        chk("t4_state", state, 0);
        chk("t4_done", done, 0);
        chk("t4_count", sample_count, 5);
        chk("t4_pulse", pulses - p0, 0);
        step(0, 0, 1, 1);
        repeat (2) step(0, 0, 0, 0);
        chk("t4_armab_state", state, 0);
        chk("t4_armab_busy", busy, 0);

        // 5: otr on a skipped sample vs on a written sample
        decim = 1; capture_len = 2;
        push(0, 11, 0); push(1, 13, 0);
        step(10, 0, 1, 0);
        step(11, 0, 0, 0);
        step(12, 1, 0, 0);
        step(13, 0, 0, 0);
        repeat (3) step(14, 0, 0, 0);
        wait_done(20, "t5a_done");
        chk("t5a_otr", otr_seen, 0);
        push(0, 21, 0); push(1, 23, 1);
        step(20, 0, 1, 0);
        step(21, 0, 0, 0);
        step(22, 0, 0, 0);
        step(23, 1, 0, 0);
        repeat (3) step(24, 0, 0, 0);
        wait_done(20, "t5b_done");
        chk("t5b_otr", otr_seen, 1);

        // 6: abort from DONE, zero length ignored, clamped full-depth capture, reset mid-capture
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t6_abort_state", state, 0);
        chk("t6_abort_done", done, 0);
        capture_len = 0; decim = 0;
        step(0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 0);
        chk("t6_len0_state", state, 0);
        chk("t6_len0_busy", busy, 0);
        capture_len = 15'((1 << ADDR_W) + 5);
        base = wr_cnt;
        for (int k = 1; k <= (1 << ADDR_W); k++) push(k - 1, 12'(k), 0);
        step(0, 0, 1, 0);
        for (int k = 1; k <= (1 << ADDR_W) + 4; k++) step(12'(k), 0, 0, 0);
        wait_done(20, "t6_done");
        chk("t6_wrcnt", wr_cnt - base, 1 << ADDR_W);
        chk("t6_lastaddr", last_addr, {ADDR_W{1'b1}});
        chk("t6_count", sample_count, 1 << ADDR_W);
        chk("t6_qempty", exp_q.size(), 0);

        capture_len = 100;
        push(0, 1, 1);
        for (int k = 2; k <= 7; k++) push(k - 1, 12'(k), 0);
        step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        for (int k = 2; k <= 9; k++) step(12'(k), 0, 0, 0);
        chk("t6_pre_count", sample_count, 7);
        chk("t6_pre_otr", otr_seen, 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_wr", {wr_en, wr_addr, wr_data}, 0);
        chk("t6_rst_stat", {busy, done, done_pulse, sample_count, otr_seen, state}, 0);
        chk("t6_rst_qempty", exp_q.size(), 0);
        repeat (2) @(negedge clk_i);
        rst = 1'b0;
        repeat (3) step(0, 0, 0, 0);
        chk("t6_post_state", state, 0);
        chk("t6_post_done", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
